// File: rtl/seg7_pkg.sv
// Shared seven-segment types, the hex glyph table and width helper.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package seg7_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t SEG_OFF = 8'h00;

    // Entry n is the glyph for hex code n; bit7=a .. bit1=g, bit0=dp left clear.
    localparam logic [15:0][7:0] GLYPH_TAB = {
        8'h8E, 8'h9E, 8'h7A, 8'h9C,   // F E d C
        8'h3E, 8'hEE, 8'hF6, 8'hFE,   // b A 9 8
        8'hE0, 8'hBE, 8'hB6, 8'h66,   // 7 6 5 4
        8'hF2, 8'hDA, 8'h60, 8'hFC    // 3 2 1 0
    };

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Digit data/strobe inputs and scanned display outputs of the seven-segment driver.
// Latency: n/a (wiring only).
// Backpressure: none; load is a single-cycle strobe that is always accepted.
interface seg7_scan_driver_if
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   blank;
    logic                load;
    seg_t                seg;
    logic [DIGITS-1:0]   an;
    logic                frame_done;
    logic                upd_pend;

    modport master (
        output value, dp_in, blank, load,
        input  seg, an, frame_done, upd_pend
    );

    modport slave (
        input  value, dp_in, blank, load,
        output seg, an, frame_done, upd_pend
    );
endinterface

// File: rtl/seg7_glyph.sv
// Combinational hex code plus decimal point to segment pattern (1 = lit).
// Latency: 0 cycles.
// Backpressure: none.
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dp,
    output seg_t       seg
);
    assign seg = GLYPH_TAB[code] | {7'b0, dp};
endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit seven-segment driver with double-buffered updates; SEG7_LZB_EN adds leading-zero blanking.
// Latency: seg/an/frame_done registered one cycle after scan state; load visible within DIGITS*SCAN_DIV+1 cycles.
// Backpressure: none; load always accepted, the last load before a frame wrap is the one committed.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD      = 16,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_driver_if.slave   bus
);
    localparam int CNT_W = width_of(SCAN_DIV);
    localparam int IDX_W = width_of(DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    localparam seg_t              SEG_IDLE = ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] AN_IDLE  = {DIGITS{ACTIVE_LOW}};

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;

    logic [4*DIGITS-1:0] pend_value;
    logic [DIGITS-1:0]   pend_dp;
    logic [DIGITS-1:0]   pend_blank;
    logic                upd_pend_q;

    logic [4*DIGITS-1:0] disp_value;
    logic [DIGITS-1:0]   disp_dp;
    logic [DIGITS-1:0]   disp_blank;
    logic [DIGITS-1:0]   dark_vec;

    logic                frame_wrap;
    logic                commit;
    logic                in_guard;

    logic [3:0]          cur_code;
    logic                cur_dp;
    logic                cur_dark;
    seg_t                glyph_seg;
    seg_t                seg_n;
    logic [DIGITS-1:0]   an_n;

    seg_t                seg_q;
    logic [DIGITS-1:0]   an_q;
    logic                frame_done_q;

    assign frame_wrap = (cnt == CNT_LAST) && (idx == IDX_LAST);
    assign commit     = frame_wrap && upd_pend_q;
    assign in_guard   = (cnt < CNT_GUARD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
        end else if (bus.load) begin
            pend_value <= bus.value;
            pend_dp    <= bus.dp_in;
            pend_blank <= bus.blank;
        end
    end

    // A load coinciding with commit keeps the flag set: the fresh data is still waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_pend_q <= 1'b0;
        end else if (bus.load) begin
            upd_pend_q <= 1'b1;
        end else if (commit) begin
            upd_pend_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_value <= '0;
            disp_dp    <= '0;
            disp_blank <= '0;
        end else if (commit) begin
            disp_value <= pend_value;
            disp_dp    <= pend_dp;
            disp_blank <= pend_blank;
        end
    end

`ifdef SEG7_LZB_EN
    logic [DIGITS-1:0] lzb_mask;

    // Dark from the top digit down while code is 0 with no dp; digit 0 always shows.
    function automatic logic [DIGITS-1:0] lead_zero_mask(
        input logic [4*DIGITS-1:0] v,
        input logic [DIGITS-1:0]   d
    );
        logic [DIGITS-1:0] m;
        logic              run;
        m   = '0;
        run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run  = run & (v[4*k +: 4] == 4'h0) & ~d[k];
            m[k] = run;
        end
        return m;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lzb_mask <= lead_zero_mask('0, '0);
        end else if (commit) begin
            lzb_mask <= lead_zero_mask(pend_value, pend_dp);
        end
    end

    assign dark_vec = disp_blank | lzb_mask;
`else
    assign dark_vec = disp_blank;
`endif

    always_comb begin
        cur_code = '0;
        cur_dp   = 1'b0;
        cur_dark = 1'b0;
        an_n     = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_code = disp_value[4*k +: 4];
                cur_dp   = disp_dp[k];
                cur_dark = dark_vec[k];
                an_n[k]  = !in_guard;
            end
        end
    end

    seg7_glyph u_glyph (
        .code (cur_code),
        .dp   (cur_dp),
        .seg  (glyph_seg)
    );

    assign seg_n = (in_guard || cur_dark) ? SEG_OFF : glyph_seg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q        <= SEG_IDLE;
            an_q         <= AN_IDLE;
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg_n ^ {8{ACTIVE_LOW}};
            an_q         <= an_n ^ {DIGITS{ACTIVE_LOW}};
            frame_done_q <= frame_wrap;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;
    assign bus.upd_pend   = upd_pend_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: DIGITS=4, SCAN_DIV=4, GUARD=1, ACTIVE_LOW=0.
// Expected glyphs are hand-computed; SEG7_LZB_EN selects the blanked expectations.
module tb_seg7_scan_driver;
    import seg7_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seg7_scan_driver_if #(.DIGITS(4)) bus();

    seg7_scan_driver #(
        .DIGITS     (4),
        .SCAN_DIV   (4),
        .GUARD      (1),
        .ACTIVE_LOW (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef SEG7_LZB_EN
    localparam logic [3:0][7:0] ZERO_FRAME = {8'h00, 8'h00, 8'h00, 8'hFC};
    localparam logic [3:0][7:0] F0050      = {8'h00, 8'h00, 8'hB6, 8'hFC};
`else
    localparam logic [3:0][7:0] ZERO_FRAME = {8'hFC, 8'hFC, 8'hFC, 8'hFC};
    localparam logic [3:0][7:0] F0050      = {8'hFC, 8'hFC, 8'hB6, 8'hFC};
`endif

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        bus.load  = ld;
        bus.value = v;
        bus.dp_in = d;
        bus.blank = b;
    endtask

    // One full frame from digit 0 slot start; optional loads issued after ticks la/lb.
    task automatic frame_check(
        input string           name,
        input logic [3:0][7:0] exp_seg,
        input int              la,
        input logic [15:0]     va,
        input logic [3:0]      da, ba,
        input int              lb,
        input logic [15:0]     vb,
        input logic [3:0]      db, bb,
        input logic            pend_mid,
        input logic            pend_end
    );
        for (int j = 0; j < 16; j++) begin
            int d = j / 4;
            int c = j % 4;
            tick;
            bus.load = 1'b0;
            chk($sformatf("%s an d%0d c%0d", name, d, c), {12'b0, bus.an},
                (c == 0) ? 16'h0 : 16'(1 << d));
            chk($sformatf("%s seg d%0d c%0d", name, d, c), {8'b0, bus.seg},
                (c == 0) ? 16'h0 : {8'h0, exp_seg[d]});
            chk($sformatf("%s frame_done j%0d", name, j), {15'b0, bus.frame_done},
                (j == 15) ? 16'h1 : 16'h0);
            if ((la >= 0 && j == la + 1) || (lb >= 0 && j == lb + 1))
                chk($sformatf("%s upd_pend after load j%0d", name, j), {15'b0, bus.upd_pend}, 16'h1);
            if (j == 7)
                chk($sformatf("%s upd_pend mid", name), {15'b0, bus.upd_pend}, {15'b0, pend_mid});
            if (j == 15)
                chk($sformatf("%s upd_pend end", name), {15'b0, bus.upd_pend}, {15'b0, pend_end});
            if (j == la) drive(1'b1, va, da, ba);
            if (j == lb) drive(1'b1, vb, db, bb);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0, 4'h0, 4'h0);
        #1;
        chk("reset seg", {8'b0, bus.seg}, 16'h0);
        chk("reset an", {12'b0, bus.an}, 16'h0);
        tick;
        tick;
        chk("reset frame_done", {15'b0, bus.frame_done}, 16'h0);
        chk("reset upd_pend", {15'b0, bus.upd_pend}, 16'h0);
        rst = 1'b0;

        frame_check("f1_idle", ZERO_FRAME, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        frame_check("f2_load", ZERO_FRAME, 5, 16'h1A3F, 4'b0100, 4'h0,
                    -1, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        frame_check("f3_1a3f", {8'h60, 8'hEF, 8'hF2, 8'h8E}, 2, 16'h1234, 4'h0, 4'h0,
                    9, 16'h5678, 4'h0, 4'h0, 1'b1, 1'b0);
        frame_check("f4_5678", {8'hB6, 8'hBE, 8'hE0, 8'hFE}, 3, 16'h4321, 4'h0, 4'b0010,
                    14, 16'h9876, 4'b1001, 4'h0, 1'b1, 1'b1);
        frame_check("f5_4321", {8'h66, 8'hF2, 8'h00, 8'h60}, -1, 16'h0, 4'h0, 4'h0,
                    -1, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        frame_check("f6_9876", {8'hF7, 8'hFE, 8'hE0, 8'hBF}, 0, 16'h0050, 4'h0, 4'h0,
                    -1, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        frame_check("f7_0050", F0050, 4, 16'h0000, 4'h0, 4'h0,
                    -1, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        frame_check("f8_0000", ZERO_FRAME, 2, 16'hFFFF, 4'h0, 4'h0,
                    -1, 16'h0, 4'h0, 4'h0, 1'b1, 1'b0);

        // Partial frame of FFFF, a pending load, then reset inside digit 2's slot.
        for (int j = 0; j < 10; j++) begin
            tick;
            bus.load = 1'b0;
            if (j == 5) begin
                chk("ffff an d1", {12'b0, bus.an}, 16'h0002);
                chk("ffff seg d1", {8'b0, bus.seg}, 16'h008E);
            end
            if (j == 6) drive(1'b1, 16'h1111, 4'h0, 4'h0);
        end
        chk("pre-reset an d2", {12'b0, bus.an}, 16'h0004);
        chk("pre-reset seg d2", {8'b0, bus.seg}, 16'h008E);
        chk("pre-reset upd_pend", {15'b0, bus.upd_pend}, 16'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset seg", {8'b0, bus.seg}, 16'h0);
        chk("async reset an", {12'b0, bus.an}, 16'h0);
        chk("async reset upd_pend", {15'b0, bus.upd_pend}, 16'h0);
        tick;
        tick;
        rst = 1'b0;
        frame_check("f9_after_rst", ZERO_FRAME, -1, 16'h0, 4'h0, 4'h0,
                    -1, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multiplexed N-digit seven-segment display driver; successor to the single-digit BCD-to-segment encoder. Takes a packed vector of 4-bit digit codes, decodes full hex (0–F) with per-digit decimal point and blanking, and time-multiplexes them onto one shared segment bus with one anode line per digit. Sits between the DHT11 controller's value formatting and the board display pins. It double-buffers updates so a new value is never shown half-written.

## Interface
- DIGITS, 4: number of multiplexed digits (1..8).
- SCAN_DIV, 50000: clock cycles per digit slot (≥ GUARD+2).
- GUARD, 16: cycles at the start of each slot with all anodes off (anti-ghosting, ≥ 0).
- ACTIVE_LOW, 0: 1 inverts `seg` and `an` at the pins.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- value  in  4*DIGITS  digit codes; digit 0 = bits [3:0] = rightmost.
- dp_in  in  DIGITS  decimal point per digit.
- blank  in  DIGITS  1 = force digit dark.
- load  in  1  single-cycle strobe capturing value/dp_in/blank into the pending buffer.
- seg  out  8  segments; bit7=a, 6=b, 5=c, 4=d, 3=e, 2=f, 1=g, 0=dp; 1 = lit before polarity.
- an  out  DIGITS  one-hot digit enable; 1 = on before polarity.
- frame_done  out  1  one-cycle pulse when the last digit slot ends.
- upd_pend  out  1  pending buffer holds data not yet displayed.

## Operation
- Glyphs: 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6, A=EE, b=3E, C=9C, d=7A, E=9E, F=8E (hex, dp bit 0). The dp bit is ORed from the displayed dp flag.
- Three register sets: pending (written by `load`), display (feeds the decoder), and scan state (slot counter `cnt`, digit index `idx`).
- `load`=1 captures the inputs into pending and sets `upd_pend`.
- Commit happens on the frame-wrap cycle, when `cnt`=SCAN_DIV-1 and `idx`=DIGITS-1. If `upd_pend`=1 at commit, pending is copied to display and `upd_pend` clears.
- `load` and commit in the same cycle: the previous pending contents commit, the new data goes into pending, and `upd_pend` stays 1.
- Per slot:
  - While `cnt` < GUARD, `an` is all inactive and `seg` is all off.
  - Otherwise `an` is one-hot at `idx` and `seg` is glyph(display digit `idx`).
  - A blanked digit drives `seg` = 0x00, but its anode still scans.
- `cnt` counts 0..SCAN_DIV-1. At SCAN_DIV-1, `cnt` returns to 0 and `idx` increments, wrapping from DIGITS-1 to 0.
- Reset values: `cnt`=0, `idx`=0, display and pending = 0, `upd_pend`=0, `frame_done`=0. `seg` and `an` are all inactive, i.e. all-ones at the pins when ACTIVE_LOW=1.
- Reset mid-frame discards pending and display data; the scan restarts at digit 0 with a guard period.

## Timing
- `seg`, `an` and `frame_done` are registered, one cycle after the internal state that produces them.
- `frame_done` is high in the cycle after the frame-wrap cycle.
- Load-to-visible latency is at most one frame plus one cycle: DIGITS*SCAN_DIV+1 cycles.
- Digit k's anode is active for SCAN_DIV-GUARD consecutive cycles per frame.
- Frame period is exactly DIGITS*SCAN_DIV cycles with no jitter.
- Counter widths are $clog2(SCAN_DIV) and $clog2(DIGITS), each with a minimum of 1 bit.

## Configuration
- SEG7_LZB_EN defined: leading-zero blanking.
  - Scanning from digit DIGITS-1 downward, a digit with code 0 and dp=0 is dark until the first nonzero digit or dp=1 digit is reached.
  - Digit 0 is never suppressed.
  - This is evaluated on the display buffer at commit time and stored as a per-digit mask.
- Not defined: zeros are always shown; no mask register exists.

## Structure
- `seg7_pkg` holds:
  - the 16-entry glyph constant array;
  - `SEG_OFF` = 8'h00;
  - typedef `seg_t` (logic [7:0]).
- Sub-module `seg7_glyph`: combinational 4-bit code + dp → `seg_t`. Instantiated once, after the digit mux.
- Polarity inversion is applied only at the output registers.

## Test plan
All scenarios use DIGITS=4, SCAN_DIV=4, GUARD=1, ACTIVE_LOW=0.
- Reset then no load → all four digits show 0xFC in sequence; `an` cycles 0001,0010,0100,1000; `an`=0000 on `cnt`=0 of every slot; `frame_done` pulses every 16 cycles.
- `load` value=16'h1A3F, dp_in=4'b0100 mid-frame → old data until frame wrap, then `seg` per digit = 8E, F2, EF, 60; `upd_pend` clears at commit.
- Two `load`s in one frame (1234 then 5678) → only 5678 displayed after wrap; 1234 never appears.
- `load` on the frame-wrap cycle → earlier pending commits, new data displayed one frame later, `upd_pend` stays 1 between.
- With SEG7_LZB_EN, value=16'h0050 → digits 3,2 dark, digit 1 = B6, digit 0 = FC; value=16'h0000 → only digit 0 lit (FC).
- Assert `rst` mid-slot at `idx`=2 → outputs inactive asynchronously; after release the scan resumes at digit 0 showing 0xFC.
